// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU-side definitions for the instruction fetch controller:
// configured address/instruction widths and the fetch FSM state type.
package fetch_ctrl_pkg;

   // cpu_config: fetch address and instruction widths
   localparam int AddrWidth = 32;
   localparam int InstWidth = 32;

   // Fetch controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_MISS  = 2'd2,
      ST_FLUSH = 2'd3
   } FetchCtrlState_t;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_skid.sv
// One-entry PC + instruction holding buffer used behind the fetch output
// register. Flush wins over load, load wins over pop, so a hit arriving in
// the same edge as the entry moving out simply replaces it.
module fetch_skid
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR = AddrWidth,
   parameter int INST = InstWidth
) (
   input  logic            clk,
   input  logic            reset_,
   input  logic            flush,
   input  logic            load,
   input  logic            pop,
   input  logic [ADDR-1:0] load_pc,
   input  logic [INST-1:0] load_inst,
   output logic            valid,
   output logic [ADDR-1:0] pc,
   output logic [INST-1:0] inst
);

   // Entry storage with flush > load > pop priority
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         valid <= 1'b0;
         pc    <= '0;
         inst  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= load_pc;
         inst  <= load_inst;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end

endmodule : fetch_skid

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues I-cache requests from the address
// generator PC, tracks one in-flight request, handles misses with a held
// PC and reissue, and buffers up to two instructions (output register plus
// a one-entry skid) toward decode.
//
// Handshake to decode: an instruction is offered while inst_e_=0; it is
// taken in a cycle where inst_e_=0 and dec_stall_=1. While inst_e_=0 and
// dec_stall_=0 the offered inst_pc/inst hold still. All cache-side and
// decode-side strobes are active-low.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR = AddrWidth,
   parameter int INST = InstWidth
) (
   input  logic            clk,
   input  logic            reset_,
   input  logic [ADDR-1:0] iag_pc,
   output logic            iag_stall_,
   output logic            ic_req_,
   output logic [ADDR-1:0] ic_pc,
   input  logic            ic_hit_,
   input  logic            ic_miss_,
   input  logic            ic_fill_,
   input  logic [INST-1:0] ic_inst,
   input  logic            flush_,
   input  logic            dec_stall_,
   output logic            inst_e_,
   output logic [ADDR-1:0] inst_pc,
   output logic [INST-1:0] inst,
   output logic            busy,
   output FetchCtrlState_t dbg_state
);

   FetchCtrlState_t state_q;
   FetchCtrlState_t state_d;

   // Output register toward decode
   logic            out_v;
   logic [ADDR-1:0] out_pc;
   logic [INST-1:0] out_inst;

   // One outstanding request; its response comes exactly one cycle later
   logic            infl_v;
   logic [ADDR-1:0] infl_pc;

   // Missed PC and the pending reissue after refill
   logic [ADDR-1:0] miss_pc;
   logic            reissue;

   // Skid entry
   logic            skid_v;
   logic [ADDR-1:0] skid_pc;
   logic [INST-1:0] skid_inst;

   logic            flush_evt;
   logic            in_run;
   logic            rsp_hit;
   logic            rsp_miss;
   logic            consume;
   logic            out_free;
   logic            issue;
   logic [ADDR-1:0] req_pc;
   logic            hit_to_out;
   logic            hit_to_skid;
   logic            skid_pop;

   // Event decode: flush dominates, a simultaneous hit+miss counts as miss
   always_comb begin
      flush_evt   = ~flush_ & (state_q != ST_IDLE);
      in_run      = (state_q == ST_RUN);
      rsp_miss    = in_run & infl_v & ~ic_miss_;
      rsp_hit     = in_run & infl_v & ic_miss_ & ~ic_hit_ & flush_;
      consume     = out_v & dec_stall_;
      out_free    = ~out_v | consume;
      // Only request when any returning hit is guaranteed a slot
      issue       = in_run & ~skid_v & out_free & flush_ & ~rsp_miss;
      req_pc      = reissue ? miss_pc : iag_pc;
      // Hit goes to the output register unless older data is ahead of it
      hit_to_out  = rsp_hit & out_free & ~skid_v;
      hit_to_skid = rsp_hit & ~hit_to_out;
      skid_pop    = out_free & skid_v;
   end

   // Cache / address-generator request outputs; a reissue keeps the
   // address generator frozen so its PC is fetched next
   always_comb begin
      ic_req_    = ~issue;
      ic_pc      = issue ? req_pc : '0;
      iag_stall_ = issue & ~reissue;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = ST_RUN;
         ST_RUN: begin
            if (flush_evt)     state_d = ST_FLUSH;
            else if (rsp_miss) state_d = ST_MISS;
         end
         ST_MISS: begin
            if (flush_evt)     state_d = ST_FLUSH;
            else if (!ic_fill_) state_d = ST_RUN;
         end
         ST_FLUSH: begin
            if (flush_evt)     state_d = ST_FLUSH;
            else               state_d = ST_RUN;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // In-flight request tracking
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         infl_v  <= 1'b0;
         infl_pc <= '0;
      end else if (flush_evt) begin
         infl_v  <= 1'b0;
      end else begin
         infl_v <= issue;
         if (issue) begin
            infl_pc <= req_pc;
         end
      end
   end

   // Miss PC capture and reissue flag
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         miss_pc <= '0;
         reissue <= 1'b0;
      end else if (flush_evt) begin
         reissue <= 1'b0;
      end else begin
         if (rsp_miss) begin
            miss_pc <= infl_pc;
         end
         if ((state_q == ST_MISS) && !ic_fill_) begin
            reissue <= 1'b1;
         end else if (issue && reissue) begin
            reissue <= 1'b0;
         end
      end
   end

   // Output register: refill from skid first (older), else from a hit
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         out_v    <= 1'b0;
         out_pc   <= '0;
         out_inst <= '0;
      end else if (flush_evt) begin
         out_v <= 1'b0;
      end else if (out_free) begin
         if (skid_v) begin
            out_v    <= 1'b1;
            out_pc   <= skid_pc;
            out_inst <= skid_inst;
         end else if (hit_to_out) begin
            out_v    <= 1'b1;
            out_pc   <= infl_pc;
            out_inst <= ic_inst;
         end else begin
            out_v <= 1'b0;
         end
      end
   end

   fetch_skid #(
      .ADDR (ADDR),
      .INST (INST)
   ) u_skid (
      .clk       (clk),
      .reset_    (reset_),
      .flush     (flush_evt),
      .load      (hit_to_skid),
      .pop       (skid_pop),
      .load_pc   (infl_pc),
      .load_inst (ic_inst),
      .valid     (skid_v),
      .pc        (skid_pc),
      .inst      (skid_inst)
   );

   // Decode-side and status outputs
   always_comb begin
      inst_e_   = ~out_v;
      inst_pc   = out_pc;
      inst      = out_inst;
      busy      = (state_q == ST_MISS) | out_v | skid_v | infl_v | reissue;
      dbg_state = state_q;
   end

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a cycle task models the address generator
// and the I-cache, a scoreboard queue holds the hand-computed delivery order,
// and a negedge monitor pops and compares every instruction decode takes.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   localparam int ADDR = AddrWidth;
   localparam int INST = InstWidth;

   logic            clk;
   logic            reset_;
   logic [ADDR-1:0] iag_pc;
   logic            iag_stall_;
   logic            ic_req_;
   logic [ADDR-1:0] ic_pc;
   logic            ic_hit_;
   logic            ic_miss_;
   logic            ic_fill_;
   logic [INST-1:0] ic_inst;
   logic            flush_;
   logic            dec_stall_;
   logic            inst_e_;
   logic [ADDR-1:0] inst_pc;
   logic [INST-1:0] inst;
   logic            busy;
   FetchCtrlState_t dbg_state;

   logic [ADDR-1:0] exp_q[$];
   logic [ADDR-1:0] mon_pc;
   int              n_chk;
   int              n_pass;

   // Environment knobs
   logic            redir_en;
   logic [ADDR-1:0] redir_pc;
   logic            miss_en;
   logic [ADDR-1:0] miss_addr;

   fetch_ctrl #(.ADDR(ADDR), .INST(INST)) dut (
      .clk        (clk),
      .reset_     (reset_),
      .iag_pc     (iag_pc),
      .iag_stall_ (iag_stall_),
      .ic_req_    (ic_req_),
      .ic_pc      (ic_pc),
      .ic_hit_    (ic_hit_),
      .ic_miss_   (ic_miss_),
      .ic_fill_   (ic_fill_),
      .ic_inst    (ic_inst),
      .flush_     (flush_),
      .dec_stall_ (dec_stall_),
      .inst_e_    (inst_e_),
      .inst_pc    (inst_pc),
      .inst       (inst),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, run did not finish");
      $fatal(1);
   end

   function automatic logic [INST-1:0] inst_of(input logic [ADDR-1:0] pc);
      return 32'hC0DE_0000 ^ {16'h0000, pc[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // One cycle: sample outputs at negedge, then after the edge update the
   // address generator and return the I-cache response to last cycle's request
   task automatic cyc(input logic stall_n, input logic flush_n, input logic fill_n,
                      input logic rst_n);
      logic            s_req;
      logic            s_adv;
      logic [ADDR-1:0] s_pc;
      s_req = (ic_req_ === 1'b0);
      s_adv = (iag_stall_ === 1'b1);
      s_pc  = ic_pc;
      @(posedge clk);
      #1;
      reset_     = rst_n;
      dec_stall_ = stall_n;
      flush_     = flush_n;
      ic_fill_   = fill_n;
      if (redir_en) begin
         iag_pc   = redir_pc;
         redir_en = 1'b0;
      end else if (s_adv) begin
         iag_pc = iag_pc + 4;
      end
      ic_hit_  = 1'b1;
      ic_miss_ = 1'b1;
      if (s_req) begin
         if (miss_en && (s_pc == miss_addr)) begin
            ic_miss_ = 1'b0;
            miss_en  = 1'b0;
         end else begin
            ic_hit_ = 1'b0;
            ic_inst = inst_of(s_pc);
         end
      end
      @(negedge clk);
   endtask

   // Reset with a fresh start PC; returns in the IDLE cycle after release
   task automatic do_reset(input logic [ADDR-1:0] pc);
      redir_en = 1'b1;
      redir_pc = pc;
      miss_en  = 1'b0;
      cyc(1, 1, 1, 0);
      cyc(1, 1, 1, 0);
      check("rst_ic_req_", 32'(ic_req_), 32'd1);
      check("rst_iag_stall_", 32'(iag_stall_), 32'd0);
      check("rst_inst_e_", 32'(inst_e_), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ic_pc", 32'(ic_pc), 32'd0);
      check("rst_inst_pc", 32'(inst_pc), 32'd0);
      check("rst_inst", 32'(inst), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      cyc(1, 1, 1, 1);
      check("idle_after_release", 32'(dbg_state), 32'(ST_IDLE));
      check("idle_no_req", 32'(ic_req_), 32'd1);
   endtask

   // Stop decode, then confirm every expected instruction was taken
   task automatic end_scn(input string name);
      cyc(0, 1, 1, 1);
      cyc(0, 1, 1, 1);
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Scoreboard monitor: compare every instruction decode takes
   always @(negedge clk) begin
      if (reset_ === 1'b1 && inst_e_ === 1'b0 && dec_stall_ === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL deliver: got pc %h expected nothing at %0t", inst_pc, $time);
         end else begin
            mon_pc = exp_q.pop_front();
            check("deliver_pc", 32'(inst_pc), 32'(mon_pc));
            check("deliver_inst", 32'(inst), 32'(inst_of(mon_pc)));
         end
      end
   end

   // Driver: directed scenarios
   initial begin
      n_chk      = 0;
      n_pass     = 0;
      reset_     = 1'b0;
      iag_pc     = '0;
      ic_hit_    = 1'b1;
      ic_miss_   = 1'b1;
      ic_fill_   = 1'b1;
      ic_inst    = '0;
      flush_     = 1'b1;
      dec_stall_ = 1'b1;
      redir_en   = 1'b0;
      redir_pc   = '0;
      miss_en    = 1'b0;
      miss_addr  = '0;
      @(negedge clk);

      // Streaming then a 4-cycle decode stall mid-stream
      do_reset(32'h100);
      exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118};
      cyc(1, 1, 1, 1);                                   // c0
      check("s_c0_req_", 32'(ic_req_), 32'd0);
      check("s_c0_pc", 32'(ic_pc), 32'h100);
      check("s_c0_iag_stall_", 32'(iag_stall_), 32'd1);
      check("s_c0_state", 32'(dbg_state), 32'(ST_RUN));
      cyc(1, 1, 1, 1);                                   // c1
      check("s_c1_pc", 32'(ic_pc), 32'h104);
      cyc(1, 1, 1, 1);                                   // c2
      check("s_c2_inst_e_", 32'(inst_e_), 32'd0);
      check("s_c2_inst_pc", 32'(inst_pc), 32'h100);
      cyc(1, 1, 1, 1);                                   // c3
      check("s_c3_inst_pc", 32'(inst_pc), 32'h104);
      cyc(1, 1, 1, 1);                                   // c4
      check("s_c4_inst_pc", 32'(inst_pc), 32'h108);
      cyc(1, 1, 1, 1);                                   // c5
      cyc(0, 1, 1, 1);                                   // c6
      cyc(0, 1, 1, 1);                                   // c7
      check("bp_req_", 32'(ic_req_), 32'd1);
      check("bp_iag_stall_", 32'(iag_stall_), 32'd0);
      check("bp_inst_pc", 32'(inst_pc), 32'h110);
      check("bp_busy", 32'(busy), 32'd1);
      cyc(0, 1, 1, 1);                                   // c8
      cyc(0, 1, 1, 1);                                   // c9
      check("bp_hold_pc", 32'(inst_pc), 32'h110);
      check("bp_hold_inst", 32'(inst), 32'(inst_of(32'h110)));
      cyc(1, 1, 1, 1);                                   // c10
      check("bp_rel_no_req", 32'(ic_req_), 32'd1);
      cyc(1, 1, 1, 1);                                   // c11
      check("bp_resume_req_", 32'(ic_req_), 32'd0);
      check("bp_resume_pc", 32'(ic_pc), 32'h118);
      cyc(1, 1, 1, 1);                                   // c12
      check("bp_bubble", 32'(inst_e_), 32'd1);
      cyc(1, 1, 1, 1);                                   // c13
      end_scn("stream_drained");

      // Flush while 0x300 hits
      do_reset(32'h300);
      exp_q = '{32'h340, 32'h344};
      cyc(1, 1, 1, 1);                                   // c0
      check("f_c0_pc", 32'(ic_pc), 32'h300);
      cyc(1, 0, 1, 1);                                   // c1: hit + flush
      check("f_c1_no_req", 32'(ic_req_), 32'd1);
      check("f_c1_iag_stall_", 32'(iag_stall_), 32'd0);
      redir_en = 1'b1;
      redir_pc = 32'h340;
      cyc(1, 1, 1, 1);                                   // c2
      check("f_c2_state", 32'(dbg_state), 32'(ST_FLUSH));
      check("f_c2_no_req", 32'(ic_req_), 32'd1);
      check("f_c2_inst_e_", 32'(inst_e_), 32'd1);
      cyc(1, 1, 1, 1);                                   // c3
      check("f_c3_state", 32'(dbg_state), 32'(ST_RUN));
      check("f_c3_req_", 32'(ic_req_), 32'd0);
      check("f_c3_pc", 32'(ic_pc), 32'h340);
      repeat (3) cyc(1, 1, 1, 1);                        // c4..c6
      end_scn("flush_drained");

      // Miss on 0x200, refill five cycles later
      do_reset(32'h200);
      miss_en   = 1'b1;
      miss_addr = 32'h200;
      exp_q = '{32'h200, 32'h204};
      cyc(1, 1, 1, 1);                                   // c0
      check("m_c0_pc", 32'(ic_pc), 32'h200);
      cyc(1, 1, 1, 1);                                   // c1: miss
      check("m_c1_no_req", 32'(ic_req_), 32'd1);
      check("m_c1_iag_stall_", 32'(iag_stall_), 32'd0);
      check("m_c1_busy", 32'(busy), 32'd1);
      for (int i = 2; i <= 5; i++) begin
         cyc(1, 1, 1, 1);
         check("m_wait_state", 32'(dbg_state), 32'(ST_MISS));
         check("m_wait_busy", 32'(busy), 32'd1);
         check("m_wait_no_req", 32'(ic_req_), 32'd1);
      end
      cyc(1, 1, 0, 1);                                   // c6: fill
      check("m_fill_busy", 32'(busy), 32'd1);
      check("m_fill_no_req", 32'(ic_req_), 32'd1);
      cyc(1, 1, 1, 1);                                   // c7: reissue
      check("m_reissue_req_", 32'(ic_req_), 32'd0);
      check("m_reissue_pc", 32'(ic_pc), 32'h200);
      check("m_reissue_iag_stall_", 32'(iag_stall_), 32'd0);
      check("m_c7_busy", 32'(busy), 32'd1);
      cyc(1, 1, 1, 1);                                   // c8
      check("m_next_pc", 32'(ic_pc), 32'h204);
      check("m_c8_busy", 32'(busy), 32'd1);
      cyc(1, 1, 1, 1);                                   // c9
      check("m_deliver_pc", 32'(inst_pc), 32'h200);
      check("m_c9_busy", 32'(busy), 32'd1);
      cyc(1, 1, 1, 1);                                   // c10
      end_scn("miss_drained");

      // Reset while in MISS, late refill afterwards
      do_reset(32'h400);
      miss_en   = 1'b1;
      miss_addr = 32'h400;
      exp_q = '{32'h500};
      cyc(1, 1, 1, 1);                                   // c0
      cyc(1, 1, 1, 1);                                   // c1: miss
      cyc(1, 1, 1, 1);                                   // c2
      check("r_c2_state", 32'(dbg_state), 32'(ST_MISS));
      redir_en = 1'b1;
      redir_pc = 32'h500;
      cyc(1, 1, 1, 0);                                   // c3: reset
      check("r_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("r_rst_busy", 32'(busy), 32'd0);
      check("r_rst_no_req", 32'(ic_req_), 32'd1);
      check("r_rst_inst_e_", 32'(inst_e_), 32'd1);
      check("r_rst_ic_pc", 32'(ic_pc), 32'd0);
      cyc(1, 1, 0, 1);                                   // c4: release + late fill
      check("r_c4_state", 32'(dbg_state), 32'(ST_IDLE));
      check("r_c4_no_req", 32'(ic_req_), 32'd1);
      check("r_c4_inst_e_", 32'(inst_e_), 32'd1);
      cyc(1, 1, 0, 1);                                   // c5: late fill again
      check("r_c5_state", 32'(dbg_state), 32'(ST_RUN));
      check("r_c5_req_", 32'(ic_req_), 32'd0);
      check("r_c5_pc", 32'(ic_pc), 32'h500);
      cyc(1, 1, 1, 1);                                   // c6
      check("r_c6_state", 32'(dbg_state), 32'(ST_RUN));
      check("r_c6_pc", 32'(ic_pc), 32'h504);
      cyc(1, 1, 1, 1);                                   // c7
      check("r_deliver_pc", 32'(inst_pc), 32'h500);
      end_scn("reset_miss_drained");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_fetch_ctrl

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR, default `AddrWidth, fetch address width.
REQ-002 SHALL have parameter INST, default `InstWidth, instruction width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port iag_pc  in  ADDR  next fetch PC from the address generator.
REQ-006 SHALL have port iag_stall_  out  1  active-low; 0 freezes the address generator's PC.
REQ-007 SHALL have port ic_req_  out  1  active-low I-cache fetch request.
REQ-008 SHALL have port ic_pc  out  ADDR  request address, valid while ic_req_=0.
REQ-009 SHALL have port ic_hit_  in  1  active-low; request of previous cycle hit, ic_inst valid.
REQ-010 SHALL have port ic_miss_  in  1  active-low; request of previous cycle missed.
REQ-011 SHALL have port ic_fill_  in  1  active-low one-cycle pulse; refill done.
REQ-012 SHALL have port ic_inst  in  INST  instruction data from the I-cache.
REQ-013 SHALL have port flush_  in  1  active-low pipeline flush (branch/jump mispredict).
REQ-014 SHALL have port dec_stall_  in  1  active-low; 0 means decode refuses the current instruction.
REQ-015 SHALL have ports inst_e_ out 1 (active-low valid), inst_pc out ADDR, inst out INST, to decode.
REQ-016 SHALL have port busy  out  1  high while in MISS or any instruction is buffered/in flight.

Function
REQ-017 SHALL implement states IDLE, RUN, MISS, FLUSH (shared enum FetchCtrlState_t).
REQ-018 SHALL transition IDLE->RUN on the first cycle after reset deassertion.
REQ-019 SHALL, in RUN, assert ic_req_=0 with ic_pc=iag_pc and iag_stall_=1 only when the skid buffer is empty and not (output valid and dec_stall_=0); otherwise ic_req_=1, iag_stall_=0.
REQ-020 SHALL record each issued request (valid bit + PC) in a one-entry in-flight register; response arrives exactly one cycle later.
REQ-021 SHALL, on ic_hit_=0, load {in-flight PC, ic_inst} into the output register if it is empty or being consumed, else into the skid buffer.
REQ-022 SHALL treat an instruction as consumed in a cycle where inst_e_=0 and dec_stall_=1; skid then moves to output in the same edge.
REQ-023 SHALL, on ic_miss_=0, go RUN->MISS, hold the missed PC, drive ic_req_=1 and iag_stall_=0.
REQ-024 SHALL, in MISS on ic_fill_=0, return to RUN and reissue the held PC in the next cycle before any iag_pc.
REQ-025 SHALL, on flush_=0 in any non-IDLE state, invalidate output, skid and in-flight entries at that edge and enter FLUSH.
REQ-026 SHALL, in FLUSH, issue no request, ignore ic_hit_/ic_miss_/ic_fill_, and go to RUN after exactly one cycle (address generator redirects meanwhile).
REQ-027 SHALL give flush_ priority over ic_hit_, ic_miss_, ic_fill_ and consumption in the same cycle.
REQ-028 SHALL never present more than two buffered instructions, never drop a hit, and never reorder instructions.
REQ-029 SHALL hold inst_pc/inst stable while inst_e_=0 and dec_stall_=0.
REQ-030 SHALL treat ic_hit_ and ic_miss_ asserted together as a miss.

Reset
REQ-031 SHALL, on reset_=0, asynchronously set state=IDLE, clear all valid bits, and drive ic_req_=1, iag_stall_=0, inst_e_=1, busy=0, ic_pc/inst_pc/inst=0.
REQ-032 SHALL abandon any outstanding miss or in-flight request on reset mid-operation; no stale hit is delivered afterwards.

Structure
REQ-033 SHALL place FetchCtrlState_t in the shared CPU package; widths come from cpu_config.
REQ-034 SHALL instantiate one sub-module, fetch_skid (1-entry PC+instruction buffer with valid); all else flat.

Verification
REQ-035 SHALL cover streaming: iag_pc 0x100,0x104,0x108, all hits, dec_stall_=1 -> inst_e_=0 with inst_pc 0x100,0x104,0x108 on consecutive cycles, two cycles after request.
REQ-036 SHALL cover miss: 0x200 misses, ic_fill_ pulse 5 cycles later -> ic_req_ reissues 0x200 next cycle, busy=1 throughout, inst_pc=0x200 delivered once.
REQ-037 SHALL cover backpressure: dec_stall_=0 for 4 cycles mid-stream -> skid fills, ic_req_=1, iag_stall_=0, no loss/duplicate on release.
REQ-038 SHALL cover flush with hit same cycle: flush_=0 while 0x300 hits -> 0x300 never delivered, one FLUSH cycle, next request from iag_pc.
REQ-039 SHALL cover reset during MISS: reset_=0 then release, late ic_fill_ -> state IDLE then RUN, inst_e_=1, no spurious reissue.
